// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB-to-register-file bus.
//   master : pipeline side; drives write-back controls/data and read indices.
//   slave  : register file; returns read data, selected write-back value and
//            the commit counter.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [DATA_WIDTH-1:0] readData;
    logic [DATA_WIDTH-1:0] ALUresult;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] wbData;
    logic [CNT_WIDTH-1:0]  commitCount;

    modport master (
        output RegWrite, MemtoReg, readData, ALUresult, writeReg, readReg1, readReg2,
        input  readData1, readData2, wbData, commitCount
    );

    modport slave (
        input  RegWrite, MemtoReg, readData, ALUresult, writeReg, readReg1, readReg2,
        output readData1, readData2, wbData, commitCount
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus 2-read/1-write architectural
// register file.
//   clk   : pipeline clock, state updates on rising edge
//   rst_n : asynchronous active-low reset (clears file and counter)
//   bus   : wb_regfile_if.slave -- write-back controls/data, two read
//           indices in; two read values, wbData and commitCount out.

// One read port: index 0 and reset force zero, a same-cycle write to the
// same index is bypassed, otherwise the stored value is returned.
module wb_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wb,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    input  logic [DATA_WIDTH-1:0] rf_val,
    output logic [DATA_WIDTH-1:0] rd_val
);
    always_comb begin
        rd_val = rf_val;
        if (!rst_n || rd_idx == '0)
            rd_val = '0;
        else if (we && wr_idx == rd_idx)
            rd_val = wb;
    end
endmodule

module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_regfile_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int NRD  = 2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]           regs [NREG];
    logic [DATA_WIDTH-1:0]           wb;
    logic [CNT_WIDTH-1:0]            cnt;
    logic [NRD-1:0][ADDR_WIDTH-1:0]  rd_idx;
    logic [NRD-1:0][DATA_WIDTH-1:0]  rf_val;
    logic [NRD-1:0][DATA_WIDTH-1:0]  rd_val;

    // Write-back select; driven whether or not RegWrite is set so EX/MEM
    // forwarding logic can always look at it.
    assign wb = bus.MemtoReg ? bus.readData : bus.ALUresult;

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.RegWrite && bus.writeReg != '0) begin
            regs[bus.writeReg] <= wb;
        end
    end

    // Counts every RegWrite cycle, including discarded writes to r0;
    // wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (bus.RegWrite) cnt <= cnt + CNT_ONE;
    end

    assign rd_idx[0] = bus.readReg1;
    assign rd_idx[1] = bus.readReg2;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rf_val[p] = regs[rd_idx[p]];
        wb_rd_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd (
            .rst_n  (rst_n),
            .we     (bus.RegWrite),
            .wr_idx (bus.writeReg),
            .wb     (wb),
            .rd_idx (rd_idx[p]),
            .rf_val (rf_val[p]),
            .rd_val (rd_val[p])
        );
    end

    assign bus.readData1   = rd_val[0];
    assign bus.readData2   = rd_val[1];
    assign bus.wbData      = wb;
    assign bus.commitCount = cnt;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  bw ();

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dutw (
        .clk(clk), .rst_n(rst_n), .bus(bw));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;   // readData1 before the edge
        logic [31:0] e2;   // readData2 before the edge
        logic [31:0] ewb;  // wbData
        logic [31:0] ecnt; // commitCount after the edge
    } vec_t;

    vec_t vt [11];

    initial begin
        // vectors run back-to-back from a clean reset
        vt[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd8, 5'd8, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd1};
        vt[1]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd9, 5'd8, 5'd9, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'd2};
        vt[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd9, 5'd8, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'd2};
        vt[3]  = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd3};
        vt[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd9, 32'h0,        32'h12345678, 32'h0,        32'd3};
        vt[5]  = '{1'b1, 1'b0, 32'h0,        32'hA,        5'd5, 5'd1, 5'd2, 32'h0,        32'h0,        32'hA,        32'd4};
        vt[6]  = '{1'b1, 1'b0, 32'h0,        32'hB,        5'd5, 5'd5, 5'd5, 32'hB,        32'hB,        32'hB,        32'd5};
        vt[7]  = '{1'b0, 1'b0, 32'h0,        32'hC,        5'd5, 5'd5, 5'd5, 32'hB,        32'hB,        32'hC,        32'd5};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        32'h55,       5'd7, 5'd7, 5'd5, 32'h0,        32'hB,        32'h55,       32'd5};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        32'h55,       5'd7, 5'd7, 5'd5, 32'h0,        32'hB,        32'h55,       32'd5};
        vt[10] = '{1'b0, 1'b0, 32'h0,        32'h55,       5'd7, 5'd7, 5'd5, 32'h0,        32'hB,        32'h55,       32'd5};

        rst_n = 1'b0;
        bus.RegWrite = 0; bus.MemtoReg = 0; bus.readData = '0; bus.ALUresult = '0;
        bus.writeReg = '0; bus.readReg1 = '0; bus.readReg2 = '0;
        bw.RegWrite = 0; bw.MemtoReg = 0; bw.readData = '0; bw.ALUresult = '0;
        bw.writeReg = '0; bw.readReg1 = '0; bw.readReg2 = '0;

        step(); step();
        bus.readReg1 = 5'd8; bus.readReg2 = 5'd31;
        #1;
        chk("reset_rd1", bus.readData1, 32'h0);
        chk("reset_rd2", bus.readData2, 32'h0);
        chk("reset_cnt", bus.commitCount, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // table-driven main function
        for (int i = 0; i < 11; i++) begin
            bus.RegWrite  = vt[i].rw;  bus.MemtoReg  = vt[i].m2r;
            bus.readData  = vt[i].rd;  bus.ALUresult = vt[i].alu;
            bus.writeReg  = vt[i].wr;  bus.readReg1  = vt[i].r1;
            bus.readReg2  = vt[i].r2;
            #1;
            chk($sformatf("v%0d_rd1", i), bus.readData1, vt[i].e1);
            chk($sformatf("v%0d_rd2", i), bus.readData2, vt[i].e2);
            chk($sformatf("v%0d_wb", i),  bus.wbData,    vt[i].ewb);
            @(posedge clk); #1;
            chk($sformatf("v%0d_cnt", i), bus.commitCount, vt[i].ecnt);
        end

        // after the last vector reg 5 still reads B and reg 7 is untouched
        bus.RegWrite = 0; bus.readReg1 = 5'd5; bus.readReg2 = 5'd7;
        #1;
        chk("post_r5", bus.readData1, 32'hB);
        chk("post_r7", bus.readData2, 32'h0);

        // X on MemtoReg with RegWrite low must not disturb reg 8
        bus.MemtoReg = 1'bx; bus.writeReg = 5'd8; bus.readData = 32'h1; bus.ALUresult = 32'h2;
        step(); step();
        bus.MemtoReg = 1'b0; bus.readReg1 = 5'd8;
        #1;
        chk("xm2r_r8", bus.readData1, 32'hDEADBEEF);
        chk("xm2r_cnt", bus.commitCount, 32'd5);

        // mid-cycle asynchronous reset clears everything immediately
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 32; r++) begin
            bus.readReg1 = r[4:0]; bus.readReg2 = 5'(31 - r);
            #1;
            chk($sformatf("rst_rd1_%0d", r), bus.readData1, 32'h0);
            chk($sformatf("rst_rd2_%0d", r), bus.readData2, 32'h0);
        end
        chk("rst_cnt", bus.commitCount, 32'h0);

        // writes held off while in reset; reads (even bypass) return 0
        bus.RegWrite = 1; bus.MemtoReg = 0; bus.writeReg = 5'd3; bus.ALUresult = 32'h1;
        bus.readReg1 = 5'd3;
        step(); step();
        chk("rst_wr_rd", bus.readData1, 32'h0);
        chk("rst_wr_cnt", bus.commitCount, 32'h0);

        // release between edges; reg 3 must still be 0, first edge commits
        @(negedge clk);
        bus.RegWrite = 0;
        rst_n = 1'b1;
        #1;
        chk("rel_r3", bus.readData1, 32'h0);
        chk("rel_cnt", bus.commitCount, 32'h0);
        bus.RegWrite = 1; bus.ALUresult = 32'h7;
        step();
        bus.RegWrite = 0;
        #1;
        chk("rel_commit_r3", bus.readData1, 32'h7);
        chk("rel_commit_cnt", bus.commitCount, 32'd1);

        // 4-bit counter wrap: 15, 0, 1 after commits 15/16/17
        chk("wrap_start", {28'h0, bw.commitCount}, 32'h0);
        bw.RegWrite = 1;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n >= 15)
                chk($sformatf("wrap_%0d", n), {28'h0, bw.commitCount}, 32'(n % 16));
        end
        bw.RegWrite = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file for the 5-stage MIPS pipeline; it consumes the MEM/WB pipeline-register outputs.
- Selects the write-back value (memory load data or ALU result) and commits it to a 32-entry register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Keeps a commit counter for debug and performance.

Parameters:
- DATA_WIDTH, 32, width of each register and of the datapath
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries
- CNT_WIDTH, 32, width of the commit counter

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- RegWrite  input  1  write enable from the MEM/WB register
- MemtoReg  input  1  1 selects readData, 0 selects ALUresult
- readData  input  DATA_WIDTH  load data from the MEM/WB register
- ALUresult  input  DATA_WIDTH  ALU result from the MEM/WB register
- writeReg  input  ADDR_WIDTH  destination register index from the MEM/WB register
- readReg1  input  ADDR_WIDTH  ID-stage source index rs
- readReg2  input  ADDR_WIDTH  ID-stage source index rt
- readData1  output  DATA_WIDTH  value of readReg1
- readData2  output  DATA_WIDTH  value of readReg2
- wbData  output  DATA_WIDTH  selected write-back value, for forwarding
- commitCount  output  CNT_WIDTH  number of cycles with RegWrite=1 since reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers clear to 0 immediately, independent of clk.
  - commitCount clears to 0.
  - While rst_n=0, no write occurs, even if RegWrite=1 on a clock edge.
  - Reads during reset return 0.
- Write-back select (combinational, no latency): wbData = MemtoReg ? readData : ALUresult. wbData is driven regardless of RegWrite.
- Commit:
  - On posedge clk, when rst_n=1 and RegWrite=1 and writeReg!=0, reg[writeReg] takes wbData.
  - When writeReg=0, no write occurs; register 0 is hardwired to 0.
- Read ports (combinational, no clock latency):
  - Index 0 returns 0 unconditionally.
  - Otherwise, if RegWrite=1 and writeReg==readRegN, readDataN returns wbData (bypass for a same-cycle write-back).
  - Otherwise readDataN returns reg[readRegN].
  - Both ports may read the same index, and both bypass together.
- commitCount:
  - Increments by 1 on each posedge with rst_n=1 and RegWrite=1. This includes writes to index 0, which are counted but not stored.
  - Wraps from 2**CNT_WIDTH-1 to 0 with no flag.
- Reset released between edges: the first eligible edge after deassertion performs a normal commit.
- X on MemtoReg while RegWrite=0: must not corrupt state.
- Only one write port exists, so no write-write conflicts are possible.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after several writes -> every readData1/readData2 index returns 0 immediately and commitCount=0. Then drive RegWrite=1, writeReg=3, ALUresult=32'h1 with rst_n still 0, and pulse clk -> reg 3 stays 0.
- Write-back select: RegWrite=1, MemtoReg=1, readData=32'hDEADBEEF, ALUresult=32'h12345678, writeReg=8, edge -> readReg1=8 returns 32'hDEADBEEF. Repeat with MemtoReg=0 and writeReg=9 -> reg 9 = 32'h12345678. commitCount=2.
- Register 0: RegWrite=1, writeReg=0, ALUresult=32'hFFFFFFFF, edge -> readReg1=0 returns 0, with no bypass before or after the edge. commitCount increments by 1.
- Bypass: reg 5 holds 32'hA. Drive RegWrite=1, writeReg=5, ALUresult=32'hB, readReg1=readReg2=5 before the edge -> both ports show 32'hB combinationally, and after the edge they still show 32'hB. With RegWrite=0, the same inputs show the stored value.
- No write: RegWrite=0, writeReg=7, ALUresult=32'h55 across 3 edges -> reg 7 is unchanged and commitCount is unchanged.
- Counter wrap: with CNT_WIDTH=4, issue 17 commits -> commitCount reads 15 after the 15th commit, 0 after the 16th, and 1 after the 17th.
